mult_unit: RTL and testbench
============================

# mult_unit

Sequential signed 32×32 multiplier for the MIPS datapath. It is the multiply-side counterpart of the iterative divider and feeds the same HI/LO register pair. It uses radix-2 Booth recoding, runs one Booth step per clock, and produces a 64-bit two's-complement product split into `hi` and `lo`. The control unit starts it with a `multOP` pulse and stalls until `done`.

## Interface
Parameters:
- None. Operand width is fixed at 32 through the package constant `MULT_W`.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-low reset.
- `multOP`  in  1  Start request, sampled on the rising edge while idle.
- `A`  in  32  Multiplicand, signed.
- `B`  in  32  Multiplier, signed.
- `busy`  out  1  High while the operation is in progress.
- `done`  out  1  One-cycle pulse when `hi`/`lo` are updated.
- `hi`  out  32  Product bits [63:32].
- `lo`  out  32  Product bits [31:0].

## Operation
- Reset (`reset`==0 at an edge): FSM goes to IDLE; counter, accumulator, multiplier and Q₋₁ are cleared; `busy`=0, `done`=0, `hi`=0, `lo`=0. Reset wins over every other input.
- States: IDLE, RUN, FIN.
- IDLE → RUN on `multOP`=1. On this edge the block loads:
  - M = sign-extended A (33 bits);
  - ACC = 0 (33 bits);
  - Q = B;
  - Q₋₁ = 0;
  - counter = 0;
  - `busy`=1.
- RUN performs one Booth step per edge, selected by {Q[0], Q₋₁}:
  - 01: ACC = ACC + M;
  - 10: ACC = ACC − M;
  - 00 or 11: ACC unchanged.
  - Then {ACC, Q, Q₋₁} is arithmetically shifted right by 1 (ACC msb replicated), and counter increments.
- RUN → FIN after the step with counter==31, i.e. 32 steps.
- FIN: `hi` = ACC[31:0], `lo` = Q, `done`=1, `busy`=0. The next state is IDLE unconditionally.
- Width rules:
  - ACC is 33 bits so that −M with M = −2³¹ does not overflow.
  - The product is exact for all operand pairs; there is no overflow flag.
- `multOP` is ignored while in RUN or FIN, and A/B changes in those states are ignored. Operands are captured only on the start edge.
- `hi`/`lo` hold their last result until the next FIN or a reset. Starting a new operation does not clear them.
- B==0 or A==0 needs no special case. It still takes the full latency.

## Timing
- Edge S samples `multOP`=1 in IDLE: `busy`=1 after S.
- Edges S+1 … S+32 are the 32 Booth steps.
- Edge S+33 (FIN): `hi`/`lo` valid, `done`=1 for exactly that cycle, `busy`=0.
- Edge S+34: `done`=0. The FSM is in IDLE and a new `multOP` can be accepted on this edge, giving a back-to-back period of 34 cycles.
- `multOP` held high continuously restarts on every edge where the FSM is in IDLE.
- Reset mid-operation:
  - No `done` is produced.
  - `hi`/`lo` go to 0 on the reset edge.
  - The first start is accepted on the first edge with `reset`=1.
- Reset asserted on the same edge as FIN also clears the outputs. `done` stays 0.

## Structure
- The shared package `mult_pkg` holds:
  - `MULT_W`=32;
  - `MULT_STEPS`=32;
  - the state enum `mult_state_t` {IDLE, RUN, FIN};
  - the Booth-pair codes.
- Sub-module `booth_step` is combinational. Its inputs are ACC[32:0], Q[31:0], Q₋₁ and M[32:0]; its outputs are the next ACC, Q and Q₋₁. This isolates the add/subtract and shift logic for unit testing.
- The top level contains the FSM, the counter, the operand registers and the output registers.

## Test plan
- A=3, B=4, single `multOP` pulse → `busy` for 33 cycles, then `done` pulse with `hi`=0x00000000, `lo`=0x0000000C.
- A=−7 (0xFFFFFFF9), B=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFDD.
- A=B=0x80000000 → `hi`=0x40000000, `lo`=0x00000000 (exercises the 33-bit ACC). Then A=B=0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001.
- Start with A=−1, B=−1, pulse `multOP` again at S+5 and S+20 with A=2, B=2 → those pulses are ignored; result `hi`=0, `lo`=1 at S+33. A new start at S+34 succeeds.
- Complete A=6, B=7 (`lo`=42). Start A=9, B=9, then drive `reset`=0 at S+10 → `hi`=`lo`=0, `busy`=0, and no `done` pulse within 40 cycles.
- Random signed pairs (≥1000), back-to-back starts → each `done` matches the 64-bit reference product, and the spacing between `done` pulses is exactly 34 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential Booth multiplier.
//   MULT_W       operand width (32)
//   MULT_STEPS   number of Booth steps per multiply (one per bit of B)
//   CNT_W        width of the step counter
//   mult_state_t FSM state encoding {IDLE, RUN, FIN}
//   BOOTH_*      codes for the {Q[0], Q-1} pair that select add/subtract/hold
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_STEPS = 32;
    localparam int CNT_W      = $clog2(MULT_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mult_state_t;

    localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD   = 2'b01;
    localparam logic [1:0] BOOTH_SUB   = 2'b10;
    localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// booth_step
// One combinational radix-2 Booth iteration: conditionally add or subtract
// the multiplicand into the accumulator, then arithmetically shift the
// concatenation {ACC, Q, Q-1} right by one bit.
// Ports:
//   acc        in  33  current accumulator (signed)
//   q          in  32  current multiplier / low product bits
//   q_m1       in  1   bit shifted out of Q on the previous step
//   m          in  33  sign-extended multiplicand
//   acc_next   out 33  accumulator after add/sub and shift
//   q_next     out 32  Q after shift
//   q_m1_next  out 1   new Q-1 (old Q[0])
module booth_step
    import mult_pkg::*;
(
    input  logic [MULT_W:0]   acc,
    input  logic [MULT_W-1:0] q,
    input  logic              q_m1,
    input  logic [MULT_W:0]   m,
    output logic [MULT_W:0]   acc_next,
    output logic [MULT_W-1:0] q_next,
    output logic              q_m1_next
);

    logic [MULT_W:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        // Arithmetic shift: the accumulator sign bit is replicated into the top.
        {acc_next, q_next, q_m1_next} = {sum[MULT_W], sum, q};
    end

endmodule

// File: rtl/mult_unit.sv
// mult_unit
// Sequential signed 32x32 multiplier using radix-2 Booth recoding, one step
// per clock. The 64-bit product is delivered as hi/lo with a one-cycle done.
// Ports:
//   clk     in  1   clock, rising edge
//   reset   in  1   synchronous, active-low reset
//   multOP  in  1   start request, honoured only while idle
//   A       in  32  multiplicand (signed)
//   B       in  32  multiplier (signed)
//   busy    out 1   operation in progress
//   done    out 1   one-cycle pulse when hi/lo are updated
//   hi      out 32  product bits [63:32]
//   lo      out 32  product bits [31:0]
module mult_unit
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              multOP,
    input  logic [MULT_W-1:0] A,
    input  logic [MULT_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [MULT_W-1:0] hi,
    output logic [MULT_W-1:0] lo
);

    mult_state_t       state;
    logic [CNT_W-1:0]  count;
    // The accumulator and multiplicand carry one extra bit so that
    // subtracting M = -2^31 cannot overflow.
    logic [MULT_W:0]   acc;
    logic [MULT_W:0]   m;
    logic [MULT_W-1:0] q;
    logic              q_m1;

    logic [MULT_W:0]   acc_next;
    logic [MULT_W-1:0] q_next;
    logic              q_m1_next;

    booth_step u_booth_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // Control FSM plus datapath registers. Operands are captured only on the
    // start edge; hi/lo are written only in FIN and otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (multOP) begin
                        m     <= {A[MULT_W-1], A};
                        acc   <= '0;
                        q     <= B;
                        q_m1  <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    q_m1  <= q_m1_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(MULT_STEPS - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // After all steps the low 32 bits of ACC are the exact
                    // upper product word; bit 32 is only a sign guard.
                    hi    <= acc[MULT_W-1:0];
                    lo    <= q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit
// Self-checking bench for mult_unit: a table of directed operand pairs,
// hand-built sequences for ignored starts and resets, and a random
// back-to-back run. Expected products sit in a queue until done appears.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        multOP;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_unit dut (
        .clk    (clk),
        .reset  (reset),
        .multOP (multOP),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_done = 0;
    logic [63:0] sb[$];
    vec_t        vecs[9];

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
        end
    endtask

    // Reference product from plain signed 64-bit arithmetic.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        return 64'(sa * sbv);
    endfunction

    // Drive a one-cycle start and queue its expected product. Operands are
    // scrambled afterwards so a design that fails to capture them shows it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        A      = a;
        B      = b;
        multOP = 1'b1;
        sb.push_back(exp);
        tick();
        multOP = 1'b0;
        A      = $urandom;
        B      = $urandom;
        check("start busy/done", 64'({busy, done}), 64'(2'b10));
    endtask

    // Wait a bounded number of cycles for done and check its latency.
    task automatic waitDone(input string name, input int exp_lat);
        int lat;
        lat = 41;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check(name, 64'(lat), 64'(exp_lat));
    endtask

    task automatic checkOutput(input string name);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: done with empty scoreboard", name);
        end else begin
            exp = sb.pop_front();
            check(name, {hi, lo}, exp);
            check({name, " busy"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic pulseIgnored();
        A      = 32'd2;
        B      = 32'd2;
        multOP = 1'b1;
        tick();
        multOP = 1'b0;
    endtask

    initial begin
        int          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd3,        32'd4,        32'h00000000, 32'h0000000C};
        vecs[1] = '{32'hFFFFFFF9, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[4] = '{32'd6,        32'd7,        32'h00000000, 32'h0000002A};
        vecs[5] = '{32'd0,        32'h12345678, 32'h00000000, 32'h00000000};
        vecs[6] = '{32'h12345678, 32'd0,        32'h00000000, 32'h00000000};
        vecs[7] = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};
        vecs[8] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};

        reset  = 1'b0;
        multOP = 1'b0;
        A      = 32'd0;
        B      = 32'd0;
        repeat (3) tick();
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        reset = 1'b1;

        $display("[TB] directed table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});
            waitDone("table latency", 33);
            checkOutput("table product");
        end

        $display("[TB] ignored starts while running");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        check("hold across start", {hi, lo}, 64'hC0000000_80000000);
        repeat (4) tick();
        pulseIgnored();
        repeat (14) tick();
        pulseIgnored();
        waitDone("ignore latency", 13);
        checkOutput("ignore product");
        applyStimulus(32'd3, 32'd4, 64'd12);
        waitDone("restart latency", 33);
        checkOutput("restart product");

        $display("[TB] reset mid-operation");
        applyStimulus(32'd9, 32'd9, 64'd81);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        check("midreset hi/lo", {hi, lo}, 64'd0);
        check("midreset busy/done", 64'({busy, done}), 64'd0);
        sb.delete();
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("no done after reset", 64'(done_seen), 64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        applyStimulus(32'd6, 32'd7, 64'd42);
        waitDone("post-reset latency", 33);
        checkOutput("post-reset product");

        $display("[TB] reset on the FIN edge");
        applyStimulus(32'd5, 32'd5, 64'd25);
        repeat (32) tick();
        reset = 1'b0;
        tick();
        check("fin-reset done", 64'(done), 64'd0);
        check("fin-reset hi/lo", {hi, lo}, 64'd0);
        sb.delete();
        reset = 1'b1;
        tick();

        $display("[TB] random back-to-back");
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb, refProduct(ra, rb));
            waitDone("random latency", 33);
            checkOutput("random product");
            if (i > 0) check("done spacing", 64'(cyc - last_done), 64'd34);
            last_done = cyc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
